// File: rtl/serial_rr_scheduler.sv
// Round-robin arbiter that hands one serial bit-line (and the detector behind it)
// to one of N requesters at a time: grant, detector clear pulse, then W bits MSB-first.
module serial_rr_scheduler #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data,
    output logic [N-1:0]     gnt,
    output logic             det_clr,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic [IW-1:0]    last_id
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          ptr;
    logic [W-1:0]           shreg;
    logic [CW-1:0]          cnt;
    logic [N-1:0][W-1:0]    words;
    logic                   found;
    logic [IW-1:0]          win;
    logic [N-1:0]           gnt_c;
    int                     idx;

    assign words = data;

    // Scan starts one past the previous grantee so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        if (state_q == IDLE && found)
            gnt_c[win] = 1'b1;
    end

    // Grant is combinational, so it must also drop the instant reset asserts.
    assign gnt = areset ? '0 : gnt_c;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = CLEAR;
            CLEAR:   state_d = SHIFT;
            SHIFT:   if (cnt == CW'(W - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            ptr     <= IW'(N - 1);
            shreg   <= '0;
            cnt     <= '0;
            last_id <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (found) begin
                    shreg   <= words[win];
                    last_id <= win;
                    ptr     <= win;
                    cnt     <= '0;
                end
                SHIFT: begin
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state flops; CLEAR and SHIFT are exclusive.
    assign det_clr   = (state_q == CLEAR);
    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = ser_valid & shreg[W-1];
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rr_scheduler.sv
// Directed bench for serial_rr_scheduler: reset, frame timing/content, round-robin, abort.
module tb_serial_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           areset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data = '0;
    logic [N-1:0]   gnt;
    logic           det_clr, ser_out, ser_valid, busy;
    logic [1:0]     last_id;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] wd [N] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};

    serial_rr_scheduler #(.N(N), .W(W)) dut (
        .clk(clk), .areset(areset), .req(req), .data(data), .gnt(gnt),
        .det_clr(det_clr), .ser_out(ser_out), .ser_valid(ser_valid),
        .busy(busy), .last_id(last_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle with req already set; checks one whole frame.
    task automatic run_frame(input int id, input logic [W-1:0] word, input int drop_bit);
        #1;
        check("gnt_idle", gnt, 32'(1 << id));
        check("busy_idle", busy, 0);
        @(posedge clk); #1;
        check("clr_det", det_clr, 1);
        check("clr_valid", ser_valid, 0);
        check("clr_busy", busy, 1);
        check("clr_gnt", gnt, 0);
        check("clr_last_id", last_id, id);
        for (int i = 0; i < W; i++) begin
            @(posedge clk); #1;
            if (i == drop_bit) begin
                req = '0;
                #1;
            end
            check("bit_valid", ser_valid, 1);
            check("bit_data", ser_out, word[W-1-i]);
            check("bit_det_clr", det_clr, 0);
            check("bit_gnt", gnt, 0);
        end
        @(posedge clk); #1;
        check("end_busy", busy, 0);
        check("end_valid", ser_valid, 0);
    endtask

    initial begin
        data = {wd[3], wd[2], wd[1], wd[0]};

        // 1: reset holds everything idle even with all requests up
        req = 4'b1111;
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", ser_valid, 0);
        check("rst_det_clr", det_clr, 0);
        check("rst_last_id", last_id, 0);
        check("rst_ser_out", ser_out, 0);
        req = '0;
        @(posedge clk); #1;
        areset = 1'b0;
        @(posedge clk); #1;
        check("idle_noreq_gnt", gnt, 0);

        // 2: single frame from requester 0, first scan starts at index 0
        req = 4'b0001;
        run_frame(0, 8'hA5, 0);
        #1;
        check("after2_gnt", gnt, 0);

        // 3: all requesting, ptr at 0 -> 1,2,3,0 with wrap
        req = 4'b1111;
        run_frame(1, wd[1], -1);
        run_frame(2, wd[2], -1);
        run_frame(3, wd[3], -1);
        run_frame(0, wd[0], -1);

        // 4: grant 1, then only 1 and 3 requesting -> 3 then 1
        req = 4'b0010;
        run_frame(1, wd[1], -1);
        req = 4'b1010;
        run_frame(3, wd[3], -1);
        run_frame(1, wd[1], -1);

        // 5: abort during bit 3; ptr must return to N-1 so 0110 grants 1 not 2
        req = 4'b0010;
        #1;
        check("ab_gnt", gnt, 4'b0010);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("ab_valid_pre", ser_valid, 1);
        areset = 1'b1;
        #1;
        check("ab_valid", ser_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_det_clr", det_clr, 0);
        check("ab_gnt_rst", gnt, 0);
        check("ab_last_id", last_id, 0);
        req = 4'b0110;
        #1;
        areset = 1'b0;
        run_frame(1, wd[1], -1);

        // 6: request dropped at t+3 still gets all bits, no further grant
        req = 4'b0010;
        run_frame(1, wd[1], 1);
        #1;
        check("drop_gnt", gnt, 0);
        @(posedge clk); #1;
        check("drop_busy", busy, 0);
        check("drop_gnt2", gnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
